// File: rtl/digit_sum_pkg.sv
// digit_sum_pkg -- shared definitions for the digit_sum_scan block.
//   state_t      : scan/display FSM states
//   ASCII_*      : character bounds used by the digit decoder
//   clog2()      : constant-foldable ceiling log2 for derived widths
//   ascii_digit(): returns {is_digit, value[3:0]} for one character
// Optional feature: define DIGIT_SUM_HEX_EN to also accept A-F / a-f as
// the values 10..15. Without it only '0'..'9' are digits.
package digit_sum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DWELL  = 3'd4,
        ST_SHOW   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bit 4 flags a digit, bits 3:0 carry its numeric value.
    function automatic logic [4:0] ascii_digit(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if ((c >= ASCII_0) && (c <= ASCII_9)) begin
            r = {1'b1, 4'(c - ASCII_0)};
        end
`ifdef DIGIT_SUM_HEX_EN
        else if ((c >= ASCII_UA) && (c <= ASCII_UF)) begin
            r = {1'b1, 4'(c - ASCII_UA + 8'd10)};
        end
        else if ((c >= ASCII_LA) && (c <= ASCII_LF)) begin
            r = {1'b1, 4'(c - ASCII_LA + 8'd10)};
        end
`endif
        else begin
            r = 5'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_regfile.sv
// digit_regfile -- DEPTH x DW storage for digit_sum_scan.
//   Clk     : rising-edge clock
//   rd_addr : read address, data appears on rd_data after the next edge
//   rd_data : registered read data
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
// Contents are deliberately not reset so loaded data survives Rst.
module digit_regfile
    import digit_sum_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  DW    = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rd_data_r;

    // Single write port; the caller muxes host and scan writes.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read, one cycle of latency, read-before-write.
    always_ff @(posedge Clk) begin
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/digit_sum_scan.sv
// digit_sum_scan -- scans a small ASCII buffer, converts digits in place,
// sums them, counts non-digits, then sweeps the buffer out to a display.
//   Clk/Rst            : clock, asynchronous active-low reset
//   go/abort/loop      : start, return-to-idle, repeat display sweep
//   ld_en/addr/data    : host writes, honoured in IDLE only
//   busy/done          : status
//   sum/bad_cnt        : digit sum and non-digit count of the last scan
//   disp_data/idx/valid: displayed entry with a one-cycle change pulse
// Optional feature: DIGIT_SUM_HEX_EN (see digit_sum_pkg) accepts hex letters.
module digit_sum_scan
    import digit_sum_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  DW    = 8,
    parameter int  DWELL = 10000,
    localparam int AW    = clog2(DEPTH),
    localparam int SW    = DW + AW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          go,
    input  logic          abort,
    input  logic          loop,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sum,
    output logic [AW:0]   bad_cnt,
    output logic [DW-1:0] disp_data,
    output logic [AW-1:0] disp_idx,
    output logic          disp_valid
);

    localparam int KW = clog2(DWELL + 1);
    localparam int BW = AW + 1;

    state_t        state_r, state_nx_s;
    logic [1:0]    rst_sync_r;
    logic          srst_s, abort_s, last_i_s, last_k_s;
    logic          busy_r, busy_s, done_r, done_s;
    logic [AW-1:0] i_r;
    logic [KW-1:0] k_r;
    logic [SW-1:0] sum_r;
    logic [BW-1:0] bad_cnt_r;
    logic          is_digit_r;
    logic [3:0]    digit_val_r;
    logic [DW-1:0] disp_data_r;
    logic [AW-1:0] disp_idx_r;
    logic          disp_valid_r;
    logic [DW-1:0] rd_data_s;
    logic [4:0]    dig_code_s;
    logic          dig_ok_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;

    // Release of Rst is synchronised; until it has propagated the block
    // is held in a synchronous clear, so it cannot leave IDLE early.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign srst_s   = ~rst_sync_r[1];
    assign abort_s  = abort && (state_r != ST_IDLE);
    assign last_i_s = (i_r == AW'(DEPTH - 1));
    assign last_k_s = (k_r == KW'(DWELL - 1));

    // Upper bits beyond the ASCII byte must be zero for a digit.
    assign dig_code_s = ascii_digit(rd_data_s[7:0]);
    assign dig_ok_s   = dig_code_s[4] && ((rd_data_s >> 4'd8) == {DW{1'b0}});

    digit_regfile #(.DEPTH(DEPTH), .DW(DW)) u_regfile (
        .Clk     (Clk),
        .rd_addr (i_r),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s)
    );

    // Write-port mux: host loads in IDLE, converted digits in UPDATE.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ld_addr;
        wr_data_s = ld_data;
        if (state_r == ST_IDLE) begin
            wr_en_s = ld_en;
        end else if ((state_r == ST_UPDATE) && is_digit_r && !abort) begin
            wr_en_s   = 1'b1;
            wr_addr_s = i_r;
            wr_data_s = DW'(digit_val_r);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // State register plus registered status outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (srst_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nx_s = state_r;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nx_s = go ? ST_READ : ST_IDLE;
                ST_READ:   state_nx_s = ST_CHECK;
                ST_CHECK:  state_nx_s = ST_UPDATE;
                ST_UPDATE: state_nx_s = last_i_s ? ST_DWELL : ST_READ;
                ST_DWELL:  state_nx_s = last_k_s ? ST_SHOW : ST_DWELL;
                ST_SHOW:   state_nx_s = (!last_i_s || loop) ? ST_DWELL : ST_DONE;
                ST_DONE:   state_nx_s = go ? ST_DONE : ST_IDLE;
                default:   state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Status decode from the next state so the registered copy is aligned.
    always_comb begin
        busy_s = 1'b1;
        done_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin busy_s = 1'b0; done_s = 1'b0; end
            ST_DONE: begin busy_s = 1'b1; done_s = 1'b1; end
            default: begin busy_s = 1'b1; done_s = 1'b0; end
        endcase
    end

    // Datapath: index/dwell counters, accumulators and display registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            i_r          <= '0;
            k_r          <= '0;
            sum_r        <= '0;
            bad_cnt_r    <= '0;
            is_digit_r   <= 1'b0;
            digit_val_r  <= 4'd0;
            disp_data_r  <= '0;
            disp_idx_r   <= '0;
            disp_valid_r <= 1'b0;
        end else if (srst_s) begin
            i_r          <= '0;
            k_r          <= '0;
            sum_r        <= '0;
            bad_cnt_r    <= '0;
            is_digit_r   <= 1'b0;
            digit_val_r  <= 4'd0;
            disp_data_r  <= '0;
            disp_idx_r   <= '0;
            disp_valid_r <= 1'b0;
        end else begin
            disp_valid_r <= 1'b0;
            // On abort everything holds, leaving partial results visible.
            if (!abort_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (go) begin
                            i_r       <= '0;
                            k_r       <= '0;
                            sum_r     <= '0;
                            bad_cnt_r <= '0;
                        end
                    end
                    ST_CHECK: begin
                        is_digit_r  <= dig_ok_s;
                        digit_val_r <= dig_code_s[3:0];
                    end
                    ST_UPDATE: begin
                        if (is_digit_r) begin
                            sum_r <= sum_r + SW'(digit_val_r);
                        end else begin
                            bad_cnt_r <= bad_cnt_r + BW'(1'b1);
                        end
                        if (last_i_s) begin
                            i_r <= '0;
                            k_r <= '0;
                        end else begin
                            i_r <= i_r + AW'(1'b1);
                        end
                    end
                    ST_DWELL: k_r <= k_r + KW'(1'b1);
                    ST_SHOW: begin
                        // rd_data_s already holds mem[i]: address i has
                        // been stable through the preceding DWELL cycles.
                        disp_data_r  <= rd_data_s;
                        disp_idx_r   <= i_r;
                        disp_valid_r <= 1'b1;
                        k_r          <= '0;
                        if (!last_i_s) begin
                            i_r <= i_r + AW'(1'b1);
                        end else if (loop) begin
                            i_r <= '0;
                        end else begin
                            i_r <= i_r;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign sum        = sum_r;
    assign bad_cnt    = bad_cnt_r;
    assign disp_data  = disp_data_r;
    assign disp_idx   = disp_idx_r;
    assign disp_valid = disp_valid_r;

endmodule

// File: tb/tb_digit_sum_scan.sv
// Bench for digit_sum_scan: table vectors, random buffers checked against a
// character-rule model, loop/abort/reset sequences.
module tb_digit_sum_scan;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int DWELL = 3;
`ifdef DIGIT_SUM_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        go = 1'b0, abort = 1'b0, loop = 1'b0, ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [7:0]  ld_data = 8'd0;
    logic        busy, done, disp_valid;
    logic [11:0] sum;
    logic [4:0]  bad_cnt;
    logic [7:0]  disp_data;
    logic [3:0]  disp_idx;

    int errors = 0;
    int checks = 0;

    digit_sum_scan #(.DEPTH(DEPTH), .DW(DW), .DWELL(DWELL)) dut (
        .Clk(Clk), .Rst(Rst), .go(go), .abort(abort), .loop(loop),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .done(done), .sum(sum), .bad_cnt(bad_cnt),
        .disp_data(disp_data), .disp_idx(disp_idx), .disp_valid(disp_valid)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] text;
        int           exp_sum;
        int           exp_bad;
        int           sweeps;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    function automatic int digit_value(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (HEX_EN && c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (HEX_EN && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic void model_scan(input logic [7:0] m_in[16], output logic [7:0] m_out[16],
                                       output int s, output int b);
        int v;
        s = 0;
        b = 0;
        for (int j = 0; j < 16; j++) begin
            v = digit_value(m_in[j]);
            if (v >= 0) begin
                m_out[j] = 8'(v);
                s += v;
            end else begin
                m_out[j] = m_in[j];
                b++;
            end
        end
    endfunction

    function automatic void text_bytes(input logic [127:0] t, output logic [7:0] b[16]);
        for (int j = 0; j < 16; j++) b[j] = t[8*(15-j) +: 8];
    endfunction

    task automatic load(input logic [7:0] b[16]);
        for (int j = 0; j < 16; j++) begin
            ld_en = 1'b1;
            ld_addr = 4'(j);
            ld_data = b[j];
            step();
        end
        ld_en = 1'b0;
    endtask

    // Start a scan and follow it through every display pulse to DONE/IDLE.
    task automatic run_scan(input string tag, input logic [7:0] exp_mem[16],
                            input int exp_sum, input int exp_bad, input int sweeps);
        int n, seen, last_n, wraps, idx_prev;
        go = 1'b1;
        loop = (sweeps > 1);
        step();
        check({tag, " busy_after_go"}, busy, 1);
        n = 0; seen = 0; last_n = 0; wraps = 0; idx_prev = -1;
        while (seen < 16 * sweeps && n < 4000) begin
            // host writes while busy must be ignored
            ld_en = 1'b1;
            ld_addr = 4'($urandom_range(0, 15));
            ld_data = 8'($urandom_range(0, 255));
            step();
            n++;
            if (disp_valid) begin
                if (seen == 0) begin
                    check({tag, " first_disp_latency"}, n, 3 * DEPTH + DWELL + 1);
                    check({tag, " sum"}, sum, exp_sum);
                    check({tag, " bad_cnt"}, bad_cnt, exp_bad);
                end else begin
                    check({tag, " disp_interval"}, n - last_n, DWELL + 1);
                end
                check({tag, " disp_idx"}, disp_idx, seen % 16);
                check({tag, " disp_data"}, disp_data, exp_mem[seen % 16]);
                if (idx_prev == 15 && disp_idx == 4'd0) wraps++;
                idx_prev = int'(disp_idx);
                last_n = n;
                seen++;
                if (seen > 16 * (sweeps - 1)) loop = 1'b0;
            end
        end
        ld_en = 1'b0;
        check({tag, " pulse_count"}, seen, 16 * sweeps);
        check({tag, " wraps"}, wraps, sweeps - 1);
        check({tag, " done_at_end"}, done, 1);
        step();
        step();
        check({tag, " done_held"}, done, 1);
        check({tag, " disp_idx_held"}, disp_idx, 15);
        check({tag, " sum_held"}, sum, exp_sum);
        check({tag, " no_extra_pulse"}, disp_valid, 0);
        go = 1'b0;
        step();
        check({tag, " done_drop"}, done, 0);
        check({tag, " busy_drop"}, busy, 0);
    endtask

    initial begin
        logic [7:0] raw[16];
        logic [7:0] conv[16];
        logic [7:0] conv2[16];
        int s, b, s2, b2, pick;

        vecs[0] = '{"1234567890123456", 66, 0, 1};
`ifdef DIGIT_SUM_HEX_EN
        vecs[1] = '{"AAAAAAAAAAAAAAAA", 160, 0, 1};
        vecs[3] = '{"/0:9@AFG`afg1234", 69, 6, 1};
`else
        vecs[1] = '{"AAAAAAAAAAAAAAAA", 0, 16, 1};
        vecs[3] = '{"/0:9@AFG`afg1234", 19, 10, 1};
`endif
        vecs[2] = '{"9999999999999999", 144, 0, 2};

        // reset state
        step();
        step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset bad_cnt", bad_cnt, 0);
        check("reset disp_valid", disp_valid, 0);
        check("reset disp_data", disp_data, 0);
        Rst = 1'b1;
        step(); step(); step();

        // table vectors
        for (int t = 0; t < 4; t++) begin
            text_bytes(vecs[t].text, raw);
            load(raw);
            model_scan(raw, conv, s, b);
            run_scan($sformatf("vec%0d", t), conv, vecs[t].exp_sum, vecs[t].exp_bad, vecs[t].sweeps);
            if (t == 0) begin
                // converted values 0..9 are no longer ASCII digits
                model_scan(conv, conv2, s2, b2);
                run_scan("rescan", conv2, 0, 16, 1);
            end
        end

        // random buffers against the model
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 16; j++) begin
                pick = $urandom_range(0, 3);
                if (pick < 2)       raw[j] = 8'h30 + 8'($urandom_range(0, 9));
                else if (pick == 2) raw[j] = ($urandom_range(0, 1) == 1 ? 8'h41 : 8'h61) + 8'($urandom_range(0, 6));
                else                raw[j] = 8'($urandom_range(0, 255));
            end
            load(raw);
            model_scan(raw, conv, s, b);
            run_scan($sformatf("rand%0d", r), conv, s, b, 1);
        end

        // abort during the READ of entry 5, go held high alongside
        text_bytes(vecs[0].text, raw);
        load(raw);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 0; c < 15; c++) step();
        abort = 1'b1;
        go = 1'b1;
        step();
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        abort = 1'b0;
        go = 1'b0;
        check("abort sum_hold", sum, 15);
        check("abort bad_hold", bad_cnt, 0);
        step(); step();
        check("abort stays_idle", busy, 0);
        for (int j = 0; j < 16; j++)
            check($sformatf("abort mem%0d", j), dut.u_regfile.mem_r[j], (j < 5) ? 32'(j + 1) : 32'(raw[j]));

        // asynchronous reset in the middle of DWELL
        load(raw);
        go = 1'b1;
        step();
        for (int c = 0; c < 54; c++) step();
        check("pre_rst disp_data", disp_data, 1);
        check("pre_rst busy", busy, 1);
        #2;
        Rst = 1'b0;
        #1;
        check("async_rst busy", busy, 0);
        check("async_rst done", done, 0);
        check("async_rst sum", sum, 0);
        check("async_rst bad_cnt", bad_cnt, 0);
        check("async_rst disp_data", disp_data, 0);
        check("async_rst disp_idx", disp_idx, 0);
        check("async_rst disp_valid", disp_valid, 0);
        check("async_rst mem0", dut.u_regfile.mem_r[0], 1);
        check("async_rst mem15", dut.u_regfile.mem_r[15], 6);
        step();
        Rst = 1'b1;
        step();
        check("rst_sync hold_idle", busy, 0);
        go = 1'b0;
        step(); step(); step();
        check("post_rst idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
